// File: rtl/exe_pg_sequencer.sv
// Execute-stage power-gating sequencer: wakes MUL/SH on demand through a
// timed WAKE phase, stalls issue until ready, and powers down after idling.
module exe_pg_sequencer #(
    parameter int WAKE_CYC = 2,
    parameter int IDLE_CYC = 8,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    input  logic mul_req_i,
    input  logic sh_req_i,
    input  logic stall_i,
    input  logic mul_busy_i,
    input  logic sh_busy_i,
    input  logic pg_disable_i,
    output logic mul_pwr_en_o,
    output logic mul_iso_o,
    output logic mul_ready_o,
    output logic sh_pwr_en_o,
    output logic sh_iso_o,
    output logic sh_ready_o,
    output logic stall_req_o
);

    typedef enum logic [1:0] {
        PG_OFF  = 2'd0,
        PG_WAKE = 2'd1,
        PG_ON   = 2'd2
    } pg_state_e;

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (WAKE_CYC < 1 || WAKE_CYC > CNT_MAX) begin : g_bad_wake
        $error("exe_pg_sequencer: WAKE_CYC must be in 1..2^CNT_W-1");
    end
    if (IDLE_CYC < 1 || IDLE_CYC > CNT_MAX) begin : g_bad_idle
        $error("exe_pg_sequencer: IDLE_CYC must be in 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC);

    // Channel 0 is MUL, channel 1 is SH. Requests are deliberately not gated
    // by stall_i, otherwise stall_req_o could hold itself up forever.
    logic [1:0] req;
    logic [1:0] busy;
    logic [1:0] pwr_en;
    logic [1:0] iso;
    logic [1:0] ready;

    assign req  = {valid_i & sh_req_i, valid_i & mul_req_i};
    assign busy = {sh_busy_i, mul_busy_i};

    for (genvar g = 0; g < 2; g++) begin : g_ch
        pg_state_e        state;
        pg_state_e        state_nxt;
        logic [CNT_W-1:0] wake_cnt;
        logic [CNT_W-1:0] wake_cnt_nxt;
        logic [CNT_W-1:0] idle_cnt;
        logic [CNT_W-1:0] idle_cnt_nxt;
        logic             wake;

        assign wake = req[g] | pg_disable_i;

        always_ff @(posedge clk) begin
            if (rst) begin
                state    <= PG_OFF;
                wake_cnt <= '0;
                idle_cnt <= '0;
            end else begin
                state    <= state_nxt;
                wake_cnt <= wake_cnt_nxt;
                idle_cnt <= idle_cnt_nxt;
            end
        end

        always_comb begin
            state_nxt    = state;
            wake_cnt_nxt = wake_cnt;
            idle_cnt_nxt = idle_cnt;
            case (state)
                PG_OFF: begin
                    if (wake) begin
                        state_nxt    = PG_WAKE;
                        wake_cnt_nxt = WAKE_LD;
                    end
                end
                PG_WAKE: begin
                    if (wake_cnt == '0) begin
                        state_nxt    = PG_ON;
                        idle_cnt_nxt = IDLE_LD;
                    end else begin
                        wake_cnt_nxt = wake_cnt - 1'b1;
                    end
                end
                PG_ON: begin
                    // Activity always wins over an expiring idle count.
                    if (req[g] | busy[g] | pg_disable_i) begin
                        idle_cnt_nxt = IDLE_LD;
                    end else if (stall_i) begin
                        idle_cnt_nxt = idle_cnt;
                    end else if (idle_cnt != '0) begin
                        idle_cnt_nxt = idle_cnt - 1'b1;
                    end else begin
                        state_nxt = PG_OFF;
                    end
                end
                default: begin
                    state_nxt = PG_OFF;
                end
            endcase
        end

        assign pwr_en[g] = (state != PG_OFF);
        assign iso[g]    = (state != PG_ON);
        assign ready[g]  = (state == PG_ON);
    end

    assign mul_pwr_en_o = pwr_en[0];
    assign mul_iso_o    = iso[0];
    assign mul_ready_o  = ready[0];
    assign sh_pwr_en_o  = pwr_en[1];
    assign sh_iso_o     = iso[1];
    assign sh_ready_o   = ready[1];

    assign stall_req_o  = |(req & ~ready);

endmodule

// File: tb/tb_exe_pg_sequencer.sv
// Bench for exe_pg_sequencer: timing-level model checked every cycle plus
// directed scenarios with hand-computed cycle expectations.
module tb_exe_pg_sequencer;

    localparam int WAKE_CYC = 2;
    localparam int IDLE_CYC = 4;
    localparam int CNT_W    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid_i = 1'b0;
    logic mul_req_i = 1'b0;
    logic sh_req_i = 1'b0;
    logic stall_i = 1'b0;
    logic mul_busy_i = 1'b0;
    logic sh_busy_i = 1'b0;
    logic pg_disable_i = 1'b0;
    logic mul_pwr_en_o, mul_iso_o, mul_ready_o;
    logic sh_pwr_en_o, sh_iso_o, sh_ready_o;
    logic stall_req_o;

    exe_pg_sequencer #(
        .WAKE_CYC(WAKE_CYC),
        .IDLE_CYC(IDLE_CYC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .mul_req_i   (mul_req_i),
        .sh_req_i    (sh_req_i),
        .stall_i     (stall_i),
        .mul_busy_i  (mul_busy_i),
        .sh_busy_i   (sh_busy_i),
        .pg_disable_i(pg_disable_i),
        .mul_pwr_en_o(mul_pwr_en_o),
        .mul_iso_o   (mul_iso_o),
        .mul_ready_o (mul_ready_o),
        .sh_pwr_en_o (sh_pwr_en_o),
        .sh_iso_o    (sh_iso_o),
        .sh_ready_o  (sh_ready_o),
        .stall_req_o (stall_req_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    endtask

    // Model: a unit is either unpowered, powering up with some cycles left,
    // or usable with an idle budget; outputs follow directly from that.
    bit m_pwr[2];
    bit m_rdy[2];
    int m_wake_left[2];
    int m_idle[2];
    bit m_rq[2];
    bit m_bz[2];

    always @(posedge clk) begin
        m_rq[0] = valid_i & mul_req_i;
        m_rq[1] = valid_i & sh_req_i;
        m_bz[0] = mul_busy_i;
        m_bz[1] = sh_busy_i;
        cyc++;
        if (rst) begin
            checking = 1'b1;
            for (int c = 0; c < 2; c++) begin
                m_pwr[c] = 1'b0;
                m_rdy[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (!m_pwr[c]) begin
                    if (m_rq[c] || pg_disable_i) begin
                        m_pwr[c]       = 1'b1;
                        m_wake_left[c] = WAKE_CYC;
                    end
                end else if (!m_rdy[c]) begin
                    m_wake_left[c] = m_wake_left[c] - 1;
                    if (m_wake_left[c] == 0) begin
                        m_rdy[c]  = 1'b1;
                        m_idle[c] = IDLE_CYC;
                    end
                end else if (m_rq[c] || m_bz[c] || pg_disable_i) begin
                    m_idle[c] = IDLE_CYC;
                end else if (stall_i) begin
                    m_idle[c] = m_idle[c];
                end else if (m_idle[c] > 0) begin
                    m_idle[c] = m_idle[c] - 1;
                end else begin
                    m_pwr[c] = 1'b0;
                    m_rdy[c] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("mul_pwr_en", mul_pwr_en_o, m_pwr[0]);
            chk("mul_iso",    mul_iso_o,    !m_rdy[0]);
            chk("mul_ready",  mul_ready_o,  m_rdy[0]);
            chk("sh_pwr_en",  sh_pwr_en_o,  m_pwr[1]);
            chk("sh_iso",     sh_iso_o,     !m_rdy[1]);
            chk("sh_ready",   sh_ready_o,   m_rdy[1]);
            chk("stall_req",  stall_req_o,
                (valid_i & mul_req_i & !m_rdy[0]) | (valid_i & sh_req_i & !m_rdy[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int t);
        while (cyc < t) tick();
    endtask

    task automatic clr();
        valid_i      = 1'b0;
        mul_req_i    = 1'b0;
        sh_req_i     = 1'b0;
        stall_i      = 1'b0;
        mul_busy_i   = 1'b0;
        sh_busy_i    = 1'b0;
        pg_disable_i = 1'b0;
    endtask

    task automatic rand_inputs();
        valid_i      = 1'($urandom_range(0, 1));
        mul_req_i    = 1'($urandom_range(0, 1));
        sh_req_i     = 1'($urandom_range(0, 1));
        stall_i      = 1'($urandom_range(0, 1));
        mul_busy_i   = 1'($urandom_range(0, 1));
        sh_busy_i    = 1'($urandom_range(0, 1));
        pg_disable_i = 1'($urandom_range(0, 1));
    endtask

    // Starts a MUL request and returns the first cycle MUL is ready,
    // with the request still held in that cycle.
    task automatic wake_mul(output int k);
        int b;
        b = cyc;
        valid_i   = 1'b1;
        mul_req_i = 1'b1;
        go(b + 3);
        k = cyc;
    endtask

    initial begin
        int b, k, j;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            tick();
        end
        rst = 1'b0;
        clr();
        #1;
        chk("rst_mul_pwr_en", mul_pwr_en_o, 1'b0);
        chk("rst_mul_iso",    mul_iso_o,    1'b1);
        chk("rst_mul_ready",  mul_ready_o,  1'b0);
        chk("rst_sh_pwr_en",  sh_pwr_en_o,  1'b0);
        chk("rst_sh_iso",     sh_iso_o,     1'b1);
        chk("rst_sh_ready",   sh_ready_o,   1'b0);
        chk("rst_stall_req",  stall_req_o,  1'b0);
        tick();

        // MUL wake latency, then idle power-down
        b = cyc;
        valid_i   = 1'b1;
        mul_req_i = 1'b1;
        #1;
        chk("wake_c0_stall", stall_req_o, 1'b1);
        chk("wake_c0_pwr",   mul_pwr_en_o, 1'b0);
        go(b + 1); #1;
        chk("wake_c1_pwr",   mul_pwr_en_o, 1'b1);
        chk("wake_c1_iso",   mul_iso_o, 1'b1);
        chk("wake_c1_stall", stall_req_o, 1'b1);
        go(b + 2); #1;
        chk("wake_c2_stall", stall_req_o, 1'b1);
        chk("wake_c2_ready", mul_ready_o, 1'b0);
        go(b + 3); #1;
        chk("wake_c3_ready", mul_ready_o, 1'b1);
        chk("wake_c3_iso",   mul_iso_o, 1'b0);
        chk("wake_c3_stall", stall_req_o, 1'b0);
        k = b + 3;
        go(k + 1); clr();
        go(k + 5); #1;
        chk("idle_k5_ready", mul_ready_o, 1'b1);
        go(k + 6); #1;
        chk("idle_k6_pwr", mul_pwr_en_o, 1'b0);
        chk("idle_k6_iso", mul_iso_o, 1'b1);

        // Idle countdown frozen by stall_i over k+2..k+4
        tick();
        wake_mul(k);
        go(k + 1); clr();
        go(k + 2); stall_i = 1'b1;
        go(k + 5); stall_i = 1'b0;
        go(k + 8); #1;
        chk("stall_k8_ready", mul_ready_o, 1'b1);
        go(k + 9); #1;
        chk("stall_k9_pwr", mul_pwr_en_o, 1'b0);

        // Request exactly when the idle counter is zero
        tick();
        wake_mul(k);
        go(k + 1); clr();
        go(k + 5);
        valid_i   = 1'b1;
        mul_req_i = 1'b1;
        #1;
        chk("zreq_k5_stall", stall_req_o, 1'b0);
        chk("zreq_k5_ready", mul_ready_o, 1'b1);
        go(k + 6); clr();
        go(k + 10); #1;
        chk("zreq_k10_ready", mul_ready_o, 1'b1);
        go(k + 11); #1;
        chk("zreq_k11_pwr", mul_pwr_en_o, 1'b0);

        // Same with a busy pulse instead of a request
        tick();
        wake_mul(k);
        go(k + 1); clr();
        go(k + 5); mul_busy_i = 1'b1;
        go(k + 6); clr();
        go(k + 10); #1;
        chk("zbusy_k10_ready", mul_ready_o, 1'b1);
        go(k + 11); #1;
        chk("zbusy_k11_pwr", mul_pwr_en_o, 1'b0);

        // Reset asserted while MUL is in WAKE
        tick();
        b = cyc;
        valid_i   = 1'b1;
        mul_req_i = 1'b1;
        go(b + 1); #1;
        chk("rwake_in_wake", mul_pwr_en_o, 1'b1);
        rst = 1'b1;
        go(b + 2);
        rst = 1'b0;
        clr();
        #1;
        chk("rwake_pwr",   mul_pwr_en_o, 1'b0);
        chk("rwake_iso",   mul_iso_o, 1'b1);
        chk("rwake_ready", mul_ready_o, 1'b0);
        tick();

        // SH requested while MUL is already ON
        wake_mul(k);
        sh_req_i = 1'b1;
        #1;
        chk("conc_c0_stall", stall_req_o, 1'b1);
        go(k + 1); #1;
        chk("conc_c1_stall", stall_req_o, 1'b1);
        chk("conc_c1_mul",   mul_ready_o, 1'b1);
        go(k + 2); #1;
        chk("conc_c2_stall", stall_req_o, 1'b1);
        go(k + 3); #1;
        chk("conc_c3_sh",    sh_ready_o, 1'b1);
        chk("conc_c3_stall", stall_req_o, 1'b0);
        chk("conc_c3_mul",   mul_ready_o, 1'b1);
        clr();
        go(k + 15); #1;
        chk("conc_off_mul", mul_pwr_en_o, 1'b0);
        chk("conc_off_sh",  sh_pwr_en_o, 1'b0);

        // Power gating disabled, then re-enabled
        b = cyc;
        pg_disable_i = 1'b1;
        #1;
        chk("pgd_c0_stall", stall_req_o, 1'b0);
        go(b + 3); #1;
        chk("pgd_c3_mul", mul_ready_o, 1'b1);
        chk("pgd_c3_sh",  sh_ready_o, 1'b1);
        go(b + 53); #1;
        chk("pgd_hold_mul", mul_ready_o, 1'b1);
        chk("pgd_hold_sh",  sh_ready_o, 1'b1);
        j = cyc;
        go(j + 1); pg_disable_i = 1'b0;
        go(j + 5); #1;
        chk("pgd_j5_mul", mul_ready_o, 1'b1);
        chk("pgd_j5_sh",  sh_ready_o, 1'b1);
        go(j + 6); #1;
        chk("pgd_j6_mul", mul_pwr_en_o, 1'b0);
        chk("pgd_j6_sh",  sh_pwr_en_o, 1'b0);

        // Mixed random traffic, checked by the model only
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            valid_i = ($urandom_range(0, 3) == 0);
            pg_disable_i = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;
        clr();
        tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
